multdiv_sequencer: RTL
======================

# multdiv_sequencer

Processor-side initiator for the multicycle multiply/divide unit. It accepts a mult/div instruction from the execute stage and latches its operands and destination register. It then issues a one-cycle `ctrl_MULT`/`ctrl_DIV` start pulse, stalls the pipeline until `data_resultRDY` arrives or a watchdog expires, and presents a single-cycle writeback to the register file. On any exception the writeback goes to `$rstatus`.

## Interface
- `TIMEOUT`, 40, cycles spent in WAIT without `data_resultRDY` before a forced exception; legal range 2..63.
- `clock`  in  1  single clock; all state updates on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `issue_valid`  in  1  execute stage holds a mult/div instruction.
- `issue_is_div`  in  1  1 = div, 0 = mult; sampled with `issue_valid`.
- `issue_operandA`, `issue_operandB`  in  32 each  source register values.
- `issue_rd`  in  5  destination register.
- `data_result`  in  32  unit result.
- `data_exception`  in  1  unit exception, meaningful with `data_resultRDY`.
- `data_resultRDY`  in  1  unit result valid.
- `ctrl_MULT`, `ctrl_DIV`  out  1 each  start pulses to the unit.
- `data_operandA`, `data_operandB`  out  32 each  latched operands, held stable from START through DONE.
- `stall`  out  1  freeze the fetch/decode/execute stages.
- `wb_valid`  out  1  one-cycle register-file write enable.
- `wb_rd`  out  5  write address.
- `wb_data`  out  32  write data.
- `timeout`  out  1  sticky flag; set on watchdog expiry, cleared only by reset.

## Operation
- States are IDLE, START, WAIT, DONE. Reset forces IDLE. Reset clears every output, the latches, the counter and `timeout` to 0.
- IDLE
  - `stall = issue_valid` (combinational), so the issuing instruction is frozen.
  - If `issue_valid`: latch operands, `issue_rd` and `issue_is_div`, then go to START.
  - `data_resultRDY` is ignored.
- START (exactly 1 cycle)
  - Exactly one of `ctrl_DIV`/`ctrl_MULT` is high, chosen by the latched op. `stall` = 1. Counter is cleared.
  - `data_resultRDY` is ignored, because the unit may present a stale RDY.
  - Next state: WAIT.
- WAIT
  - `stall` = 1. Counter increments each cycle.
  - If `data_resultRDY`: capture `data_result` and `data_exception`, then go to DONE.
  - Else if counter == `TIMEOUT-1`: force the exception, set `timeout`, then go to DONE.
  - RDY and expiry in the same cycle: RDY wins and `timeout` stays unchanged.
- DONE (exactly 1 cycle)
  - `stall` = 0 and `wb_valid` = 1.
  - No exception: `wb_rd` = latched rd and `wb_data` = captured result.
  - Exception (unit or watchdog): `wb_rd` = 30 and `wb_data` = 4 for mult or 5 for div.
  - Next state: IDLE.
  - `issue_valid` seen in DONE belongs to the completing instruction and is not accepted. The next instruction is accepted in IDLE on the following cycle.
- Latched rd = 0 still produces a `wb_valid` pulse with `wb_rd` = 0; the register file discards it.
- `ctrl_*`, `wb_valid`, `wb_rd`, `wb_data` are 0 in every state other than the one that drives them.
- A `data_resultRDY` that arrives while in IDLE after a reset or timeout is ignored and produces no writeback.

## Timing
- Issue sampled in cycle 0 (IDLE). START is cycle 1, WAIT begins cycle 2.
- RDY sampled in cycle k gives DONE/writeback in cycle k+1.
- `stall` is high in cycles 0..k; the pipeline advances at the end of cycle k+1.
- Minimum occupancy is 4 cycles: RDY in the first WAIT cycle gives writeback in cycle 3.
- Watchdog with no RDY: DONE in cycle 2+`TIMEOUT`.
- Reset in any state takes effect at the next edge: IDLE, all outputs 0, no writeback for the aborted instruction.
- Back-to-back instructions: with the next `issue_valid` held high, the second START comes exactly 2 cycles after the first DONE.

## Test plan
- Mult, A=7, B=-3, rd=5, unit model asserts RDY 16 cycles after ctrl with result -21 -> `ctrl_MULT` high in cycle 1 only; `stall` high cycles 0..17; cycle 18 `wb_valid`=1, `wb_rd`=5, `wb_data`=0xFFFFFFEB.
- Div, A=100, B=0, model returns RDY with `data_exception`=1 -> `ctrl_DIV` one pulse; writeback `wb_rd`=30, `wb_data`=5; `timeout` stays 0.
- Div with model never asserting RDY, `TIMEOUT`=40 -> DONE in cycle 42 with `wb_rd`=30, `wb_data`=5, `timeout`=1; a late RDY afterwards causes no `wb_valid`.
- Stale RDY held high during START -> ignored; writeback occurs only after the RDY seen in WAIT, with that cycle's `data_result`.
- `reset` pulsed in the 10th WAIT cycle of a mult -> next cycle all outputs 0 and state IDLE; model RDY 5 cycles later produces no writeback; a new div issue then completes normally.
- Two back-to-back mults, rd=3 then rd=4, `issue_valid` held high -> two distinct START pulses 2 cycles apart around the first DONE; writebacks to 3 then 4 with no overlap.

Source files
------------

// File: rtl/multdiv_sequencer.sv
// Issue sequencer for the multicycle mult/div unit: latches an instruction, pulses
// the start strobe, stalls until the result or the watchdog, then writes back once.
module multdiv_sequencer #(
  parameter int TIMEOUT = 40  // legal range 2..63 (counter is 6 bits)
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        issue_valid,
  input  logic        issue_is_div,
  input  logic [31:0] issue_operandA,
  input  logic [31:0] issue_operandB,
  input  logic [4:0]  issue_rd,
  input  logic [31:0] data_result,
  input  logic        data_exception,
  input  logic        data_resultRDY,
  output logic        ctrl_MULT,
  output logic        ctrl_DIV,
  output logic [31:0] data_operandA,
  output logic [31:0] data_operandB,
  output logic        stall,
  output logic        wb_valid,
  output logic [4:0]  wb_rd,
  output logic [31:0] wb_data,
  output logic        timeout
);

  typedef enum logic [1:0] {S_IDLE, S_START, S_WAIT, S_DONE} state_t;

  localparam logic [5:0]  CNT_LAST = 6'(TIMEOUT - 1);
  localparam logic [4:0]  RD_STATUS = 5'd30;
  localparam logic [31:0] EXC_MULT = 32'd4;
  localparam logic [31:0] EXC_DIV  = 32'd5;

  state_t      state_q, state_d;
  logic [31:0] opa_q, opa_d, opb_q, opb_d;
  logic [4:0]  rd_q, rd_d;
  logic        div_q, div_d;
  logic [5:0]  cnt_q, cnt_d;
  logic [31:0] result_q, result_d;
  logic        exc_q, exc_d;
  logic        timeout_q, timeout_d;

  always_comb begin
    state_d   = state_q;
    opa_d     = opa_q;
    opb_d     = opb_q;
    rd_d      = rd_q;
    div_d     = div_q;
    cnt_d     = cnt_q;
    result_d  = result_q;
    exc_d     = exc_q;
    timeout_d = timeout_q;
    stall     = 1'b0;
    ctrl_MULT = 1'b0;
    ctrl_DIV  = 1'b0;
    wb_valid  = 1'b0;
    wb_rd     = '0;
    wb_data   = '0;
    case (state_q)
      S_IDLE: begin
        stall = issue_valid;
        if (issue_valid) begin
          opa_d   = issue_operandA;
          opb_d   = issue_operandB;
          rd_d    = issue_rd;
          div_d   = issue_is_div;
          exc_d   = 1'b0;
          state_d = S_START;
        end
      end
      // RDY is ignored here: the unit may still be showing the previous result.
      S_START: begin
        stall     = 1'b1;
        ctrl_DIV  = div_q;
        ctrl_MULT = ~div_q;
        cnt_d     = '0;
        state_d   = S_WAIT;
      end
      S_WAIT: begin
        stall = 1'b1;
        cnt_d = cnt_q + 6'd1;
        if (data_resultRDY) begin
          result_d = data_result;
          exc_d    = data_exception;
          state_d  = S_DONE;
        end else if (cnt_q == CNT_LAST) begin
          exc_d     = 1'b1;
          timeout_d = 1'b1;
          state_d   = S_DONE;
        end
      end
      S_DONE: begin
        wb_valid = 1'b1;
        if (exc_q) begin
          wb_rd   = RD_STATUS;
          wb_data = div_q ? EXC_DIV : EXC_MULT;
        end else begin
          wb_rd   = rd_q;
          wb_data = result_q;
        end
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= S_IDLE;
      opa_q     <= '0;
      opb_q     <= '0;
      rd_q      <= '0;
      div_q     <= 1'b0;
      cnt_q     <= '0;
      result_q  <= '0;
      exc_q     <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      opa_q     <= opa_d;
      opb_q     <= opb_d;
      rd_q      <= rd_d;
      div_q     <= div_d;
      cnt_q     <= cnt_d;
      result_q  <= result_d;
      exc_q     <= exc_d;
      timeout_q <= timeout_d;
    end
  end

  assign data_operandA = opa_q;
  assign data_operandB = opb_q;
  assign timeout       = timeout_q;

endmodule
